// File: rtl/sp_ram_arbiter.sv
// Two-master req/gnt/rvalid arbiter in front of one single-port RAM; grant is combinational, rvalid one cycle after grant.
// One access per cycle; a losing master holds req (round-robin, or m0 priority with an m1 starvation guard).
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    prio_mode_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic       r_last;
    logic [3:0] r_wait;
    logic [1:0] r_rv;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_pick1;

    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_pick1 = 1'b0;
        if (rst_n) begin
            if (m0_req_i && m1_req_i) begin
                // Contention: the starvation guard only matters in fixed-priority mode
                w_pick1 = prio_mode_i ? (r_wait == LP_MAX_WAIT) : (r_last == 1'b0);
                w_gnt1  = w_pick1;
                w_gnt0  = !w_pick1;
            end else begin
                w_gnt0 = m0_req_i;
                w_gnt1 = m1_req_i;
            end
        end
    end

    assign m0_gnt_o = w_gnt0;
    assign m1_gnt_o = w_gnt1;
    assign ram_en_o = w_gnt0 | w_gnt1;

    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        if (w_gnt0) begin
            ram_addr_o  = m0_addr_i;
            ram_wdata_o = m0_wdata_i;
            ram_we_o    = m0_we_i;
            ram_be_o    = m0_be_i;
        end else if (w_gnt1) begin
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
            r_wait <= 4'd0;
            r_rv   <= 2'b00;
        end else begin
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            if (m1_req_i && !w_gnt1) begin
                if (r_wait < LP_MAX_WAIT) begin
                    r_wait <= r_wait + 4'd1;
                end
            end else begin
                r_wait <= 4'd0;
            end
            r_rv <= {w_gnt1, w_gnt0};
        end
    end

    assign m0_rvalid_o = r_rv[0];
    assign m1_rvalid_o = r_rv[1];
    assign m0_rdata_o  = r_rv[0] ? ram_rdata_i : '0;
    assign m1_rdata_o  = r_rv[1] ? ram_rdata_i : '0;

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-master arbiter that shares one single-port `sp_ram` instance between a primary requester (m0, core data port) and a secondary requester (m1, debug/DMA port). It uses the PULPino req/gnt/rvalid protocol on both sides. It grants at most one access per cycle, drives the RAM address/data/enable signals from the winner, and returns the one-cycle-delayed read data with `rvalid` to the master that issued the access. Arbitration is selectable between round-robin and fixed-priority-with-starvation-guard.

## Interface
- ADDR_WIDTH, 15, byte address width; passed unchanged to the RAM (bits [14:13] select bank, [12:2] select word).
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- MAX_WAIT, 4, fixed-priority mode: consecutive stalled m1 cycles before m1 is forced to win (range 1..15).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- prio_mode_i  in  1  0 = round-robin, 1 = m0 fixed priority with starvation guard.
- mX_req_i  in  1  (X = 0,1) access request; held until granted.
- mX_gnt_o  out  1  combinational grant; the access is transferred in the cycle where req and gnt are both 1.
- mX_addr_i  in  ADDR_WIDTH  byte address.
- mX_we_i  in  1  1 = write.
- mX_be_i  in  DATA_WIDTH/8  byte enables.
- mX_wdata_i  in  DATA_WIDTH  write data.
- mX_rvalid_o  out  1  response valid, registered, one cycle after that master's grant.
- mX_rdata_o  out  DATA_WIDTH  read data; equals ram_rdata_i while mX_rvalid_o = 1, otherwise 0.
- ram_en_o  out  1  RAM enable; 1 in exactly the cycles where a grant is issued.
- ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o  out  ADDR_WIDTH / DATA_WIDTH / 1 / DATA_WIDTH/8  winner's signals; all zero when idle.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.

## Operation
**State**
- `last_q`: last granted master. Resets to 1, so m0 wins the first tie.
- `wait_q`: 4-bit m1 stall counter. Resets to 0.
- `rv_q[1:0]`: registered rvalid per master. Resets to 00.

**Arbitration** (combinational from req, mode and state)
- Only one master requesting: that master wins.
- Both requesting, round-robin mode: the master ≠ `last_q` wins.
- Both requesting, fixed mode: m0 wins, unless `wait_q` == MAX_WAIT, in which case m1 wins.
- Neither requesting: no grant; ram_en_o = 0; all ram_* outputs are 0.

**Register updates**
- On any grant, `last_q` ← winner.
- `wait_q` update:
  - increments (saturating at MAX_WAIT) when m1_req_i = 1 and m1_gnt_o = 0;
  - clears to 0 when m1 is granted or m1_req_i = 0;
  - updates in both modes but affects arbitration only in fixed mode.
- `rv_q[X]` ← mX_gnt_o, for reads and writes alike. Write responses carry rdata = ram_rdata_i and must be ignored by the master.

**Ordering and mode changes**
- Back-to-back grants to different masters are allowed. The response for cycle N goes to the master granted in cycle N, regardless of the grant made in cycle N+1.
- A change on prio_mode_i takes effect in the same cycle's arbitration. No state is cleared.

## Timing
**Reset**
- While rst_n = 0, both gnt outputs and ram_en_o are forced to 0 and all ram_* outputs are 0.
- On the edge with rst_n = 0: rv_q ← 00, last_q ← 1, wait_q ← 0.
- A response pending when reset is asserted is dropped: rvalid stays 0 in the next cycle.

**Latency**
- Grant: 0 cycles from req when uncontended.
- rvalid: exactly 1 cycle after grant.
- Throughput: 1 access per cycle.

**Output behaviour**
- mX_rvalid_o reflects rv_q directly (registered).
- mX_rdata_o is a combinational mux of ram_rdata_i.
- At most one of m0_gnt_o / m1_gnt_o is 1 in any cycle. At most one rvalid is 1 in any cycle.

**Boundary conditions**
- m1 stalled for MAX_WAIT cycles in fixed mode: m1 is granted on the next contention cycle, then `wait_q` clears.
- m1 drops req while stalled: `wait_q` clears.

## Test plan
- **Reset:** rst_n = 0 for 2 cycles with both reqs high -> no gnt, ram_en_o = 0, rvalid = 0. First tie after release -> m0 granted.
- **Single read:** m0 writes 0xDEADBEEF to address 0x0004 with be = 1111, then reads 0x0004 -> m0_rvalid_o one cycle after each grant; read rdata = 0xDEADBEEF; m1_rvalid_o stays 0.
- **Round-robin:** both reqs held high for 6 cycles, mode 0 -> grants alternate m0, m1, m0, m1, m0, m1. Each rvalid lands on the correct master one cycle later.
- **Fixed priority, MAX_WAIT = 4:** both reqs held high -> m0 granted in cycles 0–3, m1 granted in cycle 4, m0 granted in cycle 5.
- **Reset mid-operation:** m1 read granted in cycle N, rst_n = 0 in cycle N -> m1_rvalid_o = 0 in cycle N+1.
- **Bank crossing:** m0 writes address 0x0000 and m1 writes address 0x6000 (bank 3) back-to-back, then both read back -> correct data returned to each master, and ram_addr_o matches each request exactly.
